sram_rr_arbiter: RTL

//  Parametrised N-channel arbiter that merges N_CH sram-style master channels onto one sram slave port.

---
 rtl/sram_rr_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - round-robin arbiter merging N sram-style master channels onto one slave port
module sram_rr_arbiter #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            ch_en,
  input  logic [N_CH*DATA_W/8-1:0]   ch_we,
  input  logic [N_CH*ADDR_W-1:0]     ch_addr,
  input  logic [N_CH*DATA_W-1:0]     ch_data_w,
  output logic [DATA_W-1:0]          ch_data_r,
  output logic [N_CH-1:0]            ch_stall,
  output logic                       mem_en,
  output logic [DATA_W/8-1:0]        mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data_w,
  input  logic [DATA_W-1:0]          mem_data_r,
  input  logic                       mem_stall,
  output logic [N_CH-1:0]            grant_oh
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cur;
  logic               any_req;
  logic               active;

  // Modulo increment: the last channel wraps to 0 even when N_CH is not a power of two.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) == N_CH - 1) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // Round-robin search starting at rr_ptr; scanning backwards lets the closest requester win.
  always_comb begin
    int s;
    s       = 0;
    pick    = rr_ptr;
    any_req = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      s = int'(rr_ptr) + k;
      if (s >= N_CH) begin
        s = s - N_CH;
      end
      if (ch_en[s]) begin
        pick    = IDX_W'(s);
        any_req = 1'b1;
      end
    end
  end

  // Slave-side mux: a locked owner in BUSY, the fresh pick in IDLE; nothing is issued during reset.
  always_comb begin
    cur        = (state == BUSY) ? owner : pick;
    active     = !rst && ((state == BUSY) ? ch_en[owner] : any_req);
    mem_en     = active;
    mem_we     = active ? ch_we[cur*BE_W +: BE_W] : '0;
    mem_addr   = ch_addr[cur*ADDR_W +: ADDR_W];
    mem_data_w = ch_data_w[cur*DATA_W +: DATA_W];
    grant_oh   = '0;
    if (active) begin
      grant_oh[cur] = 1'b1;
    end
    ch_stall   = ch_en & ~(grant_oh & {N_CH{~mem_stall}});
    ch_data_r  = mem_data_r;
  end

  // Arbitration FSM: a stalled grant locks the owner until it completes or drops its request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (!mem_stall) begin
              rr_ptr <= next_idx(pick);
            end else begin
              owner <= pick;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!ch_en[owner]) begin
            state <= IDLE;
          end else if (!mem_stall) begin
            rr_ptr <= next_idx(owner);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
